// File: rtl/flaf_mse_pkg.sv
// Shared definitions for the MSE learning-curve monitor and the hbotflaf_top benches.
// Holds the FSM state encoding and the accumulator width rule.
package flaf_mse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SKIP  = 2'd1,
        ST_ACCUM = 2'd2
    } mse_state_e;

    // A full window of worst-case squares needs WIN_LOG2 guard bits above the square width.
    function automatic int acc_width(input int width, input int win_log2);
        return 2 * width + win_log2;
    endfunction

endpackage

// File: rtl/flaf_mse_sq_stage.sv
// Registered signed squarer: first pipeline stage of the MSE monitor.
// Squares an accepted error sample and flags it valid for one cycle.
module flaf_sq_stage #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               accept,
    input  logic               sample_valid,
    input  logic [WIDTH-1:0]   error_in,
    output logic [2*WIDTH-1:0] sq_r,
    output logic               sq_v_r
);

    logic signed [2*WIDTH-1:0] error_ext;
    logic        [2*WIDTH-1:0] sq_d;
    logic        [2*WIDTH-1:0] sq_q;
    logic                      sq_v_d;
    logic                      sq_v_q;

    // Sign-extend before multiplying so the product is evaluated at full 2*WIDTH precision.
    always_comb begin
        error_ext = $signed({{WIDTH{error_in[WIDTH-1]}}, error_in});
        sq_d      = sq_q;
        sq_v_d    = 1'b0;
        if (!clear && accept && sample_valid) begin
            sq_d   = $unsigned(error_ext * error_ext);
            sq_v_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sq_q   <= '0;
            sq_v_q <= 1'b0;
        end else begin
            sq_q   <= sq_d;
            sq_v_q <= sq_v_d;
        end
    end

    assign sq_r   = sq_q;
    assign sq_v_r = sq_v_q;

endmodule

// File: rtl/flaf_mse_monitor.sv
// Streaming MSE monitor: skips pipeline-fill samples, squares errors and emits
// one window-mean word per 2^WIN_LOG2 squares, plus a saturated Q.QP copy.
module flaf_mse_monitor
    import flaf_mse_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int QP       = 12,
    parameter int RET      = 6,
    parameter int WIN_LOG2 = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic               sample_valid,
    input  logic [WIDTH-1:0]   error_in,
    output logic [2*WIDTH-1:0] mse_out,
    output logic [WIDTH-1:0]   mse_q,
    output logic               mse_valid,
    output logic [15:0]        win_count
);

    localparam int ACC_W  = acc_width(WIDTH, WIN_LOG2);
    localparam int SKIP_W = (RET > 0) ? $clog2(RET + 1) : 1;
    localparam int CNT_W  = WIN_LOG2 + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << WIN_LOG2) - 1);

    mse_state_e         state_q, state_d;
    logic [SKIP_W-1:0]  skip_cnt_q, skip_cnt_d;
    logic [CNT_W-1:0]   sample_cnt_q, sample_cnt_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0] mse_out_q, mse_out_d;
    logic [WIDTH-1:0]   mse_sat_q, mse_sat_d;
    logic               mse_valid_q, mse_valid_d;
    logic [15:0]        win_count_q, win_count_d;

    logic [2*WIDTH-1:0] sq_r;
    logic               sq_v_r;
    logic [ACC_W-1:0]   acc_sum;
    logic [2*WIDTH-1:0] mse_new;
    logic [2*WIDTH-1:0] mse_shift;

    flaf_sq_stage #(
        .WIDTH(WIDTH)
    ) u_sq_stage (
        .clk         (clk),
        .reset       (reset),
        .clear       (!run),
        .accept      (state_q == ST_ACCUM),
        .sample_valid(sample_valid),
        .error_in    (error_in),
        .sq_r        (sq_r),
        .sq_v_r      (sq_v_r)
    );

    always_comb begin
        state_d      = state_q;
        skip_cnt_d   = skip_cnt_q;
        sample_cnt_d = sample_cnt_q;
        acc_d        = acc_q;
        mse_out_d    = mse_out_q;
        mse_sat_d    = mse_sat_q;
        mse_valid_d  = 1'b0;
        win_count_d  = win_count_q;

        acc_sum   = acc_q + ACC_W'(sq_r);
        mse_new   = (2*WIDTH)'(acc_sum >> WIN_LOG2);
        mse_shift = mse_new >> QP;

        // Dropping run always wins, even over a window-completing accumulate.
        if (!run) begin
            state_d      = ST_IDLE;
            skip_cnt_d   = '0;
            sample_cnt_d = '0;
            acc_d        = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (RET == 0) begin
                        state_d = ST_ACCUM;
                    end else begin
                        state_d    = ST_SKIP;
                        skip_cnt_d = SKIP_W'(RET);
                    end
                end
                ST_SKIP: begin
                    if (sample_valid) begin
                        skip_cnt_d = skip_cnt_q - SKIP_W'(1);
                        if (skip_cnt_q <= SKIP_W'(1)) begin
                            state_d = ST_ACCUM;
                        end
                    end
                end
                ST_ACCUM: begin
                    if (sq_v_r) begin
                        if (sample_cnt_q == LAST_CNT) begin
                            acc_d        = '0;
                            sample_cnt_d = '0;
                            mse_out_d    = mse_new;
                            mse_sat_d    = (|mse_shift[2*WIDTH-1:WIDTH]) ? '1 : mse_shift[WIDTH-1:0];
                            mse_valid_d  = 1'b1;
                            if (win_count_q != 16'hFFFF) begin
                                win_count_d = win_count_q + 16'd1;
                            end
                        end else begin
                            acc_d        = acc_sum;
                            sample_cnt_d = sample_cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            skip_cnt_q   <= '0;
            sample_cnt_q <= '0;
            acc_q        <= '0;
            mse_out_q    <= '0;
            mse_sat_q    <= '0;
            mse_valid_q  <= 1'b0;
            win_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            skip_cnt_q   <= skip_cnt_d;
            sample_cnt_q <= sample_cnt_d;
            acc_q        <= acc_d;
            mse_out_q    <= mse_out_d;
            mse_sat_q    <= mse_sat_d;
            mse_valid_q  <= mse_valid_d;
            win_count_q  <= win_count_d;
        end
    end

    assign mse_out   = mse_out_q;
    assign mse_q     = mse_sat_q;
    assign mse_valid = mse_valid_q;
    assign win_count = win_count_q;

endmodule

// File: tb/tb_flaf_mse_monitor.sv
// Directed bench for flaf_mse_monitor with WIN_LOG2=2, RET=2 and hand-computed
// window means; every comparison is an immediate assertion.
module tb_flaf_mse_monitor;

    localparam int WIDTH    = 16;
    localparam int QP       = 12;
    localparam int RET      = 2;
    localparam int WIN_LOG2 = 2;

    logic               clk;
    logic               reset;
    logic               run;
    logic               sample_valid;
    logic [WIDTH-1:0]   error_in;
    logic [2*WIDTH-1:0] mse_out;
    logic [WIDTH-1:0]   mse_q;
    logic               mse_valid;
    logic [15:0]        win_count;

    int check_cnt;
    int pass_cnt;

    flaf_mse_monitor #(
        .WIDTH   (WIDTH),
        .QP      (QP),
        .RET     (RET),
        .WIN_LOG2(WIN_LOG2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .sample_valid(sample_valid),
        .error_in    (error_in),
        .mse_out     (mse_out),
        .mse_q       (mse_q),
        .mse_valid   (mse_valid),
        .win_count   (win_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, then land 1 ns after the edge that consumed them.
    task automatic applyStimulus(input logic r, input logic v, input logic [WIDTH-1:0] e);
        run          = r;
        sample_valid = v;
        error_in     = e;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_cnt++;
        assert (observed === expected) pass_cnt++;
        else $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    endtask

    task automatic checkWindow(input string tag, input logic [31:0] exp_mse, input logic [15:0] exp_q,
                               input logic [15:0] exp_cnt);
        checkOutput({tag, "_valid"}, 32'(mse_valid), 32'd1);
        checkOutput({tag, "_mse_out"}, mse_out, exp_mse);
        checkOutput({tag, "_mse_q"}, 32'(mse_q), 32'(exp_q));
        checkOutput({tag, "_win_count"}, 32'(win_count), 32'(exp_cnt));
    endtask

    initial begin
        check_cnt    = 0;
        pass_cnt     = 0;
        reset        = 1'b1;
        run          = 1'b0;
        sample_valid = 1'b0;
        error_in     = '0;
        applyStimulus(1'b0, 1'b0, 16'h0000);
        applyStimulus(1'b0, 1'b0, 16'h0000);
        checkOutput("reset_mse_out", mse_out, 32'h0);
        checkOutput("reset_mse_q", 32'(mse_q), 32'h0);
        checkOutput("reset_valid", 32'(mse_valid), 32'h0);
        checkOutput("reset_win_count", 32'(win_count), 32'h0);
        reset = 1'b0;

        // Constant 1.0: two skipped, four averaged to 1.0^2.
        applyStimulus(1'b1, 1'b0, 16'h0000);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1, 16'h1000);
        checkOutput("const_early_valid", 32'(mse_valid), 32'd0);
        applyStimulus(1'b1, 1'b0, 16'h0000);
        checkWindow("const", 32'h01000000, 16'h1000, 16'd1);
        applyStimulus(1'b1, 1'b0, 16'h0000);
        checkOutput("const_pulse_width", 32'(mse_valid), 32'd0);

        // Alternating +/-0.5 back-to-back: pulses after steps 5 and 9.
        for (int i = 1; i <= 9; i++) begin
            applyStimulus(1'b1, (i <= 8), (i % 2 == 1) ? 16'h0800 : 16'hF800);
            checkOutput($sformatf("alt_valid_%0d", i), 32'(mse_valid), (i == 5 || i == 9) ? 32'd1 : 32'd0);
            if (i == 5) checkWindow("alt_w1", 32'h00400000, 16'h0400, 16'd2);
            if (i == 9) checkWindow("alt_w2", 32'h00400000, 16'h0400, 16'd3);
        end

        // Most negative error: full-width square, saturated Q output.
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 16'h8000);
        applyStimulus(1'b1, 1'b0, 16'h0000);
        checkWindow("worst", 32'h40000000, 16'hFFFF, 16'd4);

        // Gapped 1-0-0-1 valid pattern.
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, (i % 3 == 0), 16'h1000);
        checkOutput("gap_early_valid", 32'(mse_valid), 32'd0);
        applyStimulus(1'b1, 1'b0, 16'h0000);
        checkWindow("gap", 32'h01000000, 16'h1000, 16'd5);

        // Reset mid-window with win_count=5.
        applyStimulus(1'b1, 1'b1, 16'h1000);
        applyStimulus(1'b1, 1'b1, 16'h1000);
        reset = 1'b1;
        applyStimulus(1'b1, 1'b1, 16'h1000);
        checkOutput("midrst_mse_out", mse_out, 32'h0);
        checkOutput("midrst_mse_q", 32'(mse_q), 32'h0);
        checkOutput("midrst_valid", 32'(mse_valid), 32'h0);
        checkOutput("midrst_win_count", 32'(win_count), 32'h0);
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 16'h0000);

        // Fresh window after reset; skipped 4.0 samples must not leak in.
        applyStimulus(1'b1, 1'b0, 16'h0000);
        applyStimulus(1'b1, 1'b1, 16'h4000);
        applyStimulus(1'b1, 1'b1, 16'h4000);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 16'h1000);
        applyStimulus(1'b1, 1'b0, 16'h0000);
        checkWindow("post_rst", 32'h01000000, 16'h1000, 16'd1);

        // Drop run after 3 of 4 samples: no pulse, outputs hold.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 16'h0800);
        applyStimulus(1'b0, 1'b1, 16'h0800);
        checkOutput("drop_valid_a", 32'(mse_valid), 32'd0);
        applyStimulus(1'b0, 1'b0, 16'h0000);
        checkOutput("drop_valid_b", 32'(mse_valid), 32'd0);
        checkOutput("drop_mse_out", mse_out, 32'h01000000);
        checkOutput("drop_mse_q", 32'(mse_q), 32'h1000);
        checkOutput("drop_win_count", 32'(win_count), 32'd1);

        // Re-raise run: skip re-applied, next window clean.
        applyStimulus(1'b1, 1'b0, 16'h0000);
        applyStimulus(1'b1, 1'b1, 16'h4000);
        applyStimulus(1'b1, 1'b1, 16'h4000);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 16'h0800);
        checkOutput("rerun_early_valid", 32'(mse_valid), 32'd0);
        applyStimulus(1'b1, 1'b0, 16'h0000);
        checkWindow("rerun", 32'h00400000, 16'h0400, 16'd2);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
